// File: rtl/s1_pkg.sv
// Shared definitions for the stage-1 BRAM writer: frame geometry,
// address width, saturation bound and the writer state encoding.
package s1_pkg;

    localparam int IN_WIDTH_DEF  = 35;
    localparam int OUT_WIDTH_DEF = 17;
    localparam int ROWS_DEF      = 8;
    localparam int COLS_DEF      = 8;
    localparam int CHANS_DEF     = 3;

    localparam int FRAME_WORDS = ROWS_DEF * COLS_DEF * CHANS_DEF;
    localparam int ADDR_W      = 8;

    // Largest value a BRAM word can hold; anything above clips here.
    localparam logic [OUT_WIDTH_DEF-1:0] SAT_MAX = '1;
    localparam logic [OUT_WIDTH_DEF-1:0] SAT_MIN = '0;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/s1_bram_writer_relu_sat.sv
// Combinational rescale of a signed stage-1 result: arithmetic shift,
// ReLU, then clip to the unsigned BRAM word range with a clip indicator.
module relu_sat
    import s1_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int SHIFT     = 0
) (
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic        [OUT_WIDTH-1:0] out_data,
    output logic                        clipped
);

    logic signed [IN_WIDTH-1:0] shifted;

    assign shifted = in_data >>> SHIFT;

    // Negative values floor to zero; any set bit above the word width means
    // the value exceeds the largest word and is clipped to all ones.
    always_comb begin
        out_data = '0;
        clipped  = 1'b0;
        if (shifted[IN_WIDTH-1]) begin
            out_data = '0;
        end else if (|shifted[IN_WIDTH-2:OUT_WIDTH]) begin
            out_data = '1;
            clipped  = 1'b1;
        end else begin
            out_data = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/s1_bram_writer.sv
// Stage-1 output writer: takes a pixel-major, channel-interleaved stream,
// rescales each beat and writes it channel-planar into the stage-2 BRAM,
// then pulses data_done once the whole frame has landed.
module s1_bram_writer
    import s1_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int SHIFT     = 0,
    parameter int ROWS      = ROWS_DEF,
    parameter int COLS      = COLS_DEF,
    parameter int CHANS     = CHANS_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start,
    input  logic                        cons_busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        bram_we,
    output logic        [ADDR_W-1:0]    bram_addr,
    output logic        [OUT_WIDTH-1:0] bram_wdata,
    output logic                        data_done,
    output logic                        busy,
    output logic                        sat_flag
);

    localparam int CHA_W = (CHANS > 1) ? $clog2(CHANS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    state_t               state;
    logic [CHA_W-1:0]     cha;
    logic [COL_W-1:0]     col;
    logic [ROW_W-1:0]     row;
    logic [OUT_WIDTH-1:0] sat_data;
    logic                 clipped;
    logic [ADDR_W-1:0]    addr_next;
    logic                 last_cha;
    logic                 last_col;
    logic                 last_row;
    logic                 accept;

    assign last_cha  = (cha == CHA_W'(CHANS - 1));
    assign last_col  = (col == COL_W'(COLS - 1));
    assign last_row  = (row == ROW_W'(ROWS - 1));
    assign accept    = in_valid && in_ready;

    // Channel-planar placement: each channel owns a contiguous ROWS*COLS plane.
    assign addr_next = ADDR_W'(cha) * ADDR_W'(ROWS * COLS)
                     + ADDR_W'(row) * ADDR_W'(COLS)
                     + ADDR_W'(col);

    relu_sat #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_relu_sat (
        .in_data  (in_data),
        .out_data (sat_data),
        .clipped  (clipped)
    );

    // Frame sequencer: waits for an allowed start, writes one word per
    // accepted beat, lets the final write drain, then signals completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cha        <= '0;
            col        <= '0;
            row        <= '0;
            in_ready   <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            data_done  <= 1'b0;
            busy       <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            bram_we   <= 1'b0;
            data_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start && !cons_busy) begin
                        state    <= WRITE;
                        cha      <= '0;
                        col      <= '0;
                        row      <= '0;
                        sat_flag <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    if (accept) begin
                        bram_we    <= 1'b1;
                        bram_addr  <= addr_next;
                        bram_wdata <= sat_data;
                        if (clipped) begin
                            sat_flag <= 1'b1;
                        end
                        if (last_cha) begin
                            cha <= '0;
                            if (last_col) begin
                                col <= '0;
                                if (last_row) begin
                                    row <= '0;
                                end else begin
                                    row <= row + ROW_W'(1);
                                end
                            end else begin
                                col <= col + COL_W'(1);
                            end
                        end else begin
                            cha <= cha + CHA_W'(1);
                        end
                        if (last_cha && last_col && last_row) begin
                            state    <= FLUSH;
                            in_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state     <= DONE;
                    data_done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/s1_bram_writer.md
Name: s1_bram_writer

Overview:
- Stage-1 output writer: the producer end of the BRAM interface that `etapa2` reads.
- Accepts a stream of signed stage-1 convolution results and applies ReLU, right-shift and saturation to 17-bit unsigned.
- Writes one full 8x8x3 frame (192 words) into the stage-2 input BRAM in channel-planar layout, then pulses `data_done` to start stage 2.
- Never starts a frame while stage 2 reports busy, so a frame stage 2 is still reading is never overwritten.

Parameters:
- IN_WIDTH, 35, width of the signed stage-1 result.
- OUT_WIDTH, 17, BRAM word width (unsigned).
- SHIFT, 0, arithmetic right shift applied before saturation (fixed-point rescale).
- ROWS, 8, rows per channel plane.
- COLS, 8, columns per channel plane.
- CHANS, 3, channels per frame.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- frame_start  in  1  one-cycle request to begin a new frame
- cons_busy  in  1  stage-2 `busy`; high means the BRAM is being read
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid and in_ready are both high
- in_data  in  IN_WIDTH  signed stage-1 result
- bram_we  out  1  BRAM write enable
- bram_addr  out  8  BRAM write address
- bram_wdata  out  OUT_WIDTH  BRAM write data
- data_done  out  1  one-cycle pulse: frame fully written
- busy  out  1  high from frame accept until the data_done cycle, inclusive
- sat_flag  out  1  sticky per frame: at least one beat clipped at the upper bound

Behaviour:
- Reset (rst=0 on a clk edge):
  - state=IDLE, all counters 0, all outputs 0.
  - A partially written frame is abandoned; no data_done is produced for it.
- States:
  - IDLE: in_ready=0. When frame_start=1 and cons_busy=0, go to WRITE and clear counters and sat_flag.
  - frame_start while cons_busy=1 is dropped, not queued.
  - WRITE: in_ready=1. Each accepted beat advances the counters. The 192nd accepted beat moves to FLUSH.
  - FLUSH: in_ready=0. The last write issues this cycle. Go to DONE.
  - DONE: data_done=1 for exactly one cycle, busy still 1. Go to IDLE.
- Input order: pixel-major, channels interleaved.
  - cha increments fastest (0..CHANS-1), then col (0..COLS-1), then row (0..ROWS-1).
  - Each counter wraps to 0 and carries into the next.
- Address mapping: bram_addr = cha*ROWS*COLS + row*COLS + col, giving the range 0..191.
  - Example: pixel (row 0, col 0) ch2 goes to address 128.
  - Example: (row 7, col 7) ch0 goes to address 63.
- Arithmetic on in_data:
  - v = in_data >>> SHIFT.
  - If v < 0, output 0 (ReLU).
  - Else if v > 2^OUT_WIDTH-1, output 2^OUT_WIDTH-1 and set sat_flag.
  - Else output v[OUT_WIDTH-1:0].
- Latency: a beat accepted at cycle t appears as bram_we=1, with its address and data registered, at cycle t+1. Exactly one write per accepted beat.
- data_done rises at t+2 relative to the last accepted beat.
- Boundaries:
  - frame_start during WRITE/FLUSH/DONE is ignored.
  - in_valid=0 gaps stall the counters with no write.
  - cons_busy is sampled only in IDLE.
  - sat_flag holds after data_done until the next frame is accepted.
  - bram_we is never high outside the cycle after an accepted beat.

Decomposition:
- Package s1_pkg:
  - FRAME_WORDS = ROWS*COLS*CHANS (192).
  - Enum state_t {IDLE, WRITE, FLUSH, DONE}.
  - ADDR_W = 8.
  - Saturation bounds.
- Sub-module relu_sat: combinational shift, ReLU and saturation, with a clipped flag. Parameters IN_WIDTH, OUT_WIDTH, SHIFT.

Test Plan:
- Reset, then frame_start with cons_busy=0, then 192 beats with in_valid held high, data = index. Required response:
  - Writes at addresses 0,64,128,1,65,129,...
  - Last write at address 191.
  - data_done pulses once, 2 cycles after the last beat.
  - busy falls in the cycle after that pulse.
- Saturation, SHIFT=0: data -5 writes 0; data 131071 writes 131071 with sat_flag=0; data 131072 writes 131071 with sat_flag=1.
- SHIFT=4: data 0x320 writes 0x32.
- frame_start with cons_busy=1: no state change, in_ready stays 0. Same pulse with cons_busy=0 is accepted.
- Random in_valid gaps, about 50% duty: still exactly 192 writes, address sequence identical to the first scenario, single data_done.
- Reset asserted after beat 100: all outputs 0 next cycle, no data_done. A new frame then restarts at address 0.
